// File: rtl/dport_if.sv
// dport_if: store-in / byte-out bus of the debug output port.
// dport_ready exists only when DPORT_BACKPRESSURE_EN is defined.
interface dport_if #(parameter int AW = 2);
    logic          st_valid;
    logic          st_ready;
    logic [15:0]   st_addr;
    logic [7:0]    st_data;
    logic [7:0]    dport_out;
    logic          dport_write;
`ifdef DPORT_BACKPRESSURE_EN
    logic          dport_ready;
`endif
    logic          done;
    logic [AW:0]   fifo_level;
    modport slave (
        input  st_valid, st_addr, st_data,
`ifdef DPORT_BACKPRESSURE_EN
        input  dport_ready,
`endif
        output st_ready, dport_out, dport_write, done, fifo_level
    );
    modport master (
        output st_valid, st_addr, st_data,
`ifdef DPORT_BACKPRESSURE_EN
        output dport_ready,
`endif
        input  st_ready, dport_out, dport_write, done, fifo_level
    );
endinterface

// File: rtl/dport_ctrl.sv
// dport_ctrl: FIFO-buffered debug byte port with sticky end-of-test flag.
// Define DPORT_BACKPRESSURE_EN to add a valid/ready handshake on the byte output.
module dport_ctrl #(
    parameter logic [15:0] DPORT_ADDR = 16'hFFF0,
    parameter logic [15:0] DONE_ADDR  = 16'hFFF1,
    parameter int          DEPTH      = 4,
    parameter int          AW         = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    dport_if.slave  bus
);
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;
    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    state_e      state_q, state_d;
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, level;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  out_q, out_d;
    logic        wr_q, wr_d;
    logic        hit_d, hit_x, full, empty, ack, push, pop, acc_x;
    assign level = wptr_q - rptr_q;
    assign full  = level == FULL_LVL;
    assign empty = level == '0;
    assign hit_d = bus.st_addr == DPORT_ADDR;
    assign hit_x = bus.st_addr == DONE_ADDR;
`ifdef DPORT_BACKPRESSURE_EN
    assign ack = bus.dport_ready;
`else
    assign ack = 1'b1;
`endif
    // Ready uses pre-pop occupancy: no bypass while full.
    assign bus.st_ready   = hit_d ? !full : 1'b1;
    assign push           = bus.st_valid && bus.st_ready && hit_d && state_q == RUN;
    assign acc_x          = bus.st_valid && hit_x;
    assign pop            = !empty && (!wr_q || ack);
    assign bus.dport_out  = out_q;
    assign bus.dport_write = wr_q;
    assign bus.done       = state_q == DONE;
    assign bus.fifo_level = level;
    always_comb begin
        wptr_d  = push ? wptr_q + ONE : wptr_q;
        rptr_d  = pop ? rptr_q + ONE : rptr_q;
        out_d   = pop ? mem_q[rptr_q[AW-1:0]] : out_q;
        wr_d    = pop || (wr_q && !ack);
        state_d = (state_q == RUN && acc_x) ? DRAIN :
                  (state_q == DRAIN && empty && !wr_q) ? DONE : state_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            wptr_q  <= '0;
            rptr_q  <= '0;
            out_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            out_q   <= out_d;
            wr_q    <= wr_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= bus.st_data;
    end
endmodule

// File: tb/tb_dport_ctrl.sv
// tb_dport_ctrl: directed checks of dport_ctrl streaming, done sequencing and reset.
module tb_dport_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    always #5 clk = ~clk;
    dport_if #(.AW(2)) bus ();
    dport_ctrl #(.DPORT_ADDR(16'hFFF0), .DONE_ADDR(16'hFFF1), .DEPTH(4), .AW(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [15:0] a, input logic [7:0] d);
        bus.st_valid = v;
        bus.st_addr  = a;
        bus.st_data  = d;
        #1;
    endtask
    task automatic do_reset();
        drive(1'b0, 16'h0000, 8'h00);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask
    initial begin
        logic [7:0] exp_q [$];
        int n;
        logic acc;
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
`ifdef DPORT_BACKPRESSURE_EN
        bus.dport_ready = 1'b1;
`endif
        do_reset();
        chk("rst_out", bus.dport_out, 8'h00);
        chk("rst_write", bus.dport_write, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_level", bus.fifo_level, 3'd0);
        // single byte: one strobe the cycle after the edge following acceptance
        drive(1'b1, 16'hFFF0, 8'h41);
        chk("t1_ready", bus.st_ready, 1'b1);
        step();
        drive(1'b0, 16'h0000, 8'h00);
        chk("t1_lvl1", bus.fifo_level, 3'd1);
        chk("t1_nowr", bus.dport_write, 1'b0);
        step();
        chk("t1_wr", bus.dport_write, 1'b1);
        chk("t1_out", bus.dport_out, 8'h41);
        chk("t1_lvl0", bus.fifo_level, 3'd0);
        step();
        chk("t1_wr_end", bus.dport_write, 1'b0);
        chk("t1_hold", bus.dport_out, 8'h41);
        // four back-to-back stores
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 16'hFFF0, 8'(i));
            chk("t2_ready", bus.st_ready, 1'b1);
            step();
            if (i > 1) begin
                chk("t2_wr", bus.dport_write, 1'b1);
                chk("t2_out", bus.dport_out, 32'(i - 1));
            end
        end
        drive(1'b0, 16'h0000, 8'h00);
        step();
        chk("t2_wr4", bus.dport_write, 1'b1);
        chk("t2_out4", bus.dport_out, 8'h04);
        step();
        chk("t2_idle", bus.dport_write, 1'b0);
`ifdef DPORT_BACKPRESSURE_EN
        // backpressure: sink stalled while six bytes arrive
        do_reset();
        bus.dport_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'hFFF0, 8'(8'h10 + i));
            step();
        end
        drive(1'b1, 16'hFFF0, 8'h15);
        chk("t3_full", bus.fifo_level, 3'd4);
        chk("t3_ready0", bus.st_ready, 1'b0);
        chk("t3_held", bus.dport_out, 8'h10);
        chk("t3_held_wr", bus.dport_write, 1'b1);
        step();
        chk("t3_stable", bus.dport_out, 8'h10);
        chk("t3_stable_wr", bus.dport_write, 1'b1);
        bus.dport_ready = 1'b1;
        #1;
        n = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus.dport_write) begin
                chk("t3_order", bus.dport_out, 32'(8'h10 + n));
                n++;
            end
            acc = bus.st_valid && bus.st_ready;
            step();
            if (acc) drive(1'b0, 16'h0000, 8'h00);
        end
        chk("t3_count", n, 6);
`endif
        // done waits for the last strobe to finish
        do_reset();
        drive(1'b1, 16'hFFF0, 8'hAA);
        step();
        drive(1'b1, 16'hFFF1, 8'h5A);
        chk("t4_x_ready", bus.st_ready, 1'b1);
        step();
        drive(1'b0, 16'h0000, 8'h00);
        chk("t4_strobe", bus.dport_write, 1'b1);
        chk("t4_aa", bus.dport_out, 8'hAA);
        chk("t4_done_lo1", bus.done, 1'b0);
        step();
        chk("t4_strobe_end", bus.dport_write, 1'b0);
        chk("t4_done_lo2", bus.done, 1'b0);
        step();
        chk("t4_done_hi", bus.done, 1'b1);
        drive(1'b1, 16'hFFF0, 8'hBB);
        chk("t4_bb_ready", bus.st_ready, 1'b1);
        step();
        drive(1'b1, 16'hFFF1, 8'h00);
        step();
        drive(1'b0, 16'h0000, 8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("t4_bb_level", bus.fifo_level, 3'd0);
            chk("t4_bb_nowr", bus.dport_write, 1'b0);
            chk("t4_sticky", bus.done, 1'b1);
            step();
        end
        // store to unrelated address
        do_reset();
        drive(1'b1, 16'h0200, 8'h55);
        chk("t5_ready", bus.st_ready, 1'b1);
        step();
        drive(1'b0, 16'h0000, 8'h00);
        chk("t5_level", bus.fifo_level, 3'd0);
        step();
        chk("t5_nowr", bus.dport_write, 1'b0);
        chk("t5_done", bus.done, 1'b0);
        // reset mid-stream with done pending
        do_reset();
`ifdef DPORT_BACKPRESSURE_EN
        bus.dport_ready = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'hFFF0, 8'(8'hC0 + i));
            step();
        end
        drive(1'b1, 16'hFFF1, 8'h00);
        step();
        drive(1'b0, 16'h0000, 8'h00);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
`ifdef DPORT_BACKPRESSURE_EN
        bus.dport_ready = 1'b1;
`endif
        chk("t6_wr", bus.dport_write, 1'b0);
        chk("t6_done", bus.done, 1'b0);
        chk("t6_level", bus.fifo_level, 3'd0);
        step();
        chk("t6_nostale", bus.dport_write, 1'b0);
        drive(1'b1, 16'hFFF0, 8'h77);
        step();
        drive(1'b0, 16'h0000, 8'h00);
        step();
        chk("t6_new_wr", bus.dport_write, 1'b1);
        chk("t6_new_out", bus.dport_out, 8'h77);
        step();
        chk("t6_new_end", bus.dport_write, 1'b0);
        chk("t6_done_lo", bus.done, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
